if_pc_stage: RTL and testbench
==============================

// Module: if_pc_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline: owns the word-addressed PC, drives the
//   instruction-memory address, and registers the IF/ID pipeline latch.
//   Consumes the redirect target produced by the branch target calculator (new_pc) plus a taken
//   flag. Also consumes the hazard-unit stall.
//   A taken branch that arrives during a stall is held in a one-entry pending-redirect buffer
//   until the stall releases.
// PARAMETERS
//   PC_WIDTH     32        width of PC, branch target and IF/ID PC field
//   INSTR_WIDTH  32        instruction word width
//   RESET_PC     32'h0     PC value loaded on reset (word address)
//   NOP_INSTR    32'h0     instruction injected into IF/ID on a bubble (sll $0,$0,0)
// PORTS
//   clk            in   1            rising-edge clock
//   reset          in   1            synchronous, active-high reset
//   stall          in   1            hazard unit: hold PC and IF/ID
//   branch_taken   in   1            redirect request, one-cycle pulse per branch
//   branch_target  in   PC_WIDTH     redirect word address (new_pc from branch calc)
//   imem_addr      out  PC_WIDTH     instruction-memory address, combinational = pc
//   imem_rdata     in   INSTR_WIDTH  instruction at imem_addr, same cycle (async-read ROM)
//   ifid_pc        out  PC_WIDTH     PC of instruction held in IF/ID
//   ifid_instr     out  INSTR_WIDTH  instruction held in IF/ID
//   ifid_valid     out  1            1 = real instruction, 0 = bubble
//   redirect_pend  out  1            pending-redirect buffer occupied
// BEHAVIOUR
//   - Priority per cycle: reset > branch_taken > pending redirect > stall > normal fetch.
//   - Reset: pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, redirect_pend=0,
//     pend_target=0. The first valid IF/ID word appears 1 cycle after reset deasserts.
//   - Normal (no stall, no redirect):
//     - pc <= pc+1, wraps modulo 2^PC_WIDTH (PC is a word address, +1 per instruction).
//     - IF/ID <= {pc, imem_rdata, valid=1}. Latency: imem_addr to ifid_instr is 1 cycle.
//   - Stall, no redirect: pc and all IF/ID fields hold their values.
//   - branch_taken && !stall:
//     - pc <= branch_target.
//     - IF/ID <= bubble {pc=0, NOP_INSTR, valid=0}, which flushes the wrong-path fetch.
//     - Clears redirect_pend (the newer target wins).
//   - branch_taken && stall:
//     - pc holds; pend_target <= branch_target; redirect_pend <= 1.
//     - IF/ID <= bubble (flush applies even under stall).
//     - A second taken branch while pending overwrites pend_target.
//   - redirect_pend && !stall && !branch_taken:
//     - pc <= pend_target; redirect_pend <= 0.
//     - IF/ID <= bubble.
//     - Normal fetch resumes on the next cycle.
//   - redirect_pend && stall: everything holds; the buffer stays occupied.
//   - Reset asserted mid-stall or mid-pending: reset values apply and the pending target is
//     discarded.
//   - branch_target is taken as-is: no alignment check, full PC_WIDTH, no sign handling.
//   - imem_addr always equals the registered pc; no combinational path from branch inputs to
//     imem_addr.
// TESTING
//   1. reset high 2 cycles, RESET_PC=0, imem[i]=i+100, free run 4 cycles
//      -> ifid (pc,instr,valid) = (0,100,1),(1,101,1),(2,102,1); imem_addr 1,2,3,4.
//   2. stall high 3 cycles at pc=5
//      -> imem_addr stays 5; IF/ID holds (4,104,1); (5,105,1) the cycle after release.
//   3. branch_taken with target 40, no stall, at pc=7
//      -> next cycle ifid_valid=0 and instr=NOP; pc=40; then (40,140,1).
//   4. stall=1 and branch_taken (target 20) same cycle; stall held 2 more cycles
//      -> redirect_pend=1, pc holds, ifid_valid=0.
//      On stall release pc=20 and redirect_pend=0; then (20,120,1).
//   5. while pending target 20, second branch_taken with target 60 under stall
//      -> on release pc=60; target 20 is never fetched.
//   6. pc=32'hFFFF_FFFF, normal fetch -> pc wraps to 0.
//      Reset asserted while redirect_pend=1 -> pend cleared, pc=RESET_PC.

Source files
------------

// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: word-addressed PC, imem address, IF/ID latch and a
// one-entry pending-redirect buffer for taken branches that arrive during a stall.
module if_pc_stage #(
    parameter int unsigned               PC_WIDTH    = 32,
    parameter int unsigned               INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]       RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]    NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic                   ifid_valid,
    output logic                   redirect_pend
);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pend_target_q, pend_target_d;
    logic                   redirect_pend_q, redirect_pend_d;
    logic [PC_WIDTH-1:0]    ifid_pc_q, ifid_pc_d;
    logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic                   flush;

    // Priority: branch_taken > pending redirect > stall > normal fetch.
    always_comb begin
        pc_d            = pc_q;
        pend_target_d   = pend_target_q;
        redirect_pend_d = redirect_pend_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        flush           = 1'b0;

        if (branch_taken) begin
            flush = 1'b1;
            if (stall) begin
                pend_target_d   = branch_target;
                redirect_pend_d = 1'b1;
            end else begin
                pc_d            = branch_target;
                redirect_pend_d = 1'b0;
            end
        end else if (redirect_pend_q && !stall) begin
            flush           = 1'b1;
            pc_d            = pend_target_q;
            redirect_pend_d = 1'b0;
        end else if (!stall && !redirect_pend_q) begin
            pc_d         = pc_q + PC_WIDTH'(1);
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
        end

        // The wrong-path fetch is squashed even while the stage is stalled.
        if (flush) begin
            ifid_pc_d    = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            pend_target_q   <= '0;
            redirect_pend_q <= 1'b0;
            ifid_pc_q       <= '0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_valid_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            pend_target_q   <= pend_target_d;
            redirect_pend_q <= redirect_pend_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_valid    = ifid_valid_q;
    assign redirect_pend = redirect_pend_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: per-cycle expected state is queued when stimulus is
// driven and compared after the following rising edge.
module tb_if_pc_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        redirect_pend;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    if_pc_stage #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0),
        .NOP_INSTR   (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .redirect_pend (redirect_pend)
    );

    // Async-read ROM: imem[i] = i + 100.
    assign imem_rdata = imem_addr + 32'd100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, queue its expected result, then compare after the edge.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic [31:0] e_addr, input logic [31:0] e_pc,
                       input logic [31:0] e_instr, input logic e_valid, input logic e_pend);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        e.addr = e_addr; e.ipc = e_pc; e.instr = e_instr; e.valid = e_valid; e.pend = e_pend;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            g = sb_q.pop_front();
            chk("imem_addr", imem_addr, g.addr);
            chk("ifid_pc", ifid_pc, g.ipc);
            chk("ifid_instr", ifid_instr, g.instr);
            chk("ifid_valid", 32'(ifid_valid), 32'(g.valid));
            chk("redirect_pend", 32'(redirect_pend), 32'(g.pend));
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // 1: reset for 2 cycles, then free run
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   1, 0, 100, 1, 0);
        cyc(0, 0, 0, 0,   2, 1, 101, 1, 0);
        cyc(0, 0, 0, 0,   3, 2, 102, 1, 0);
        cyc(0, 0, 0, 0,   4, 3, 103, 1, 0);
        cyc(0, 0, 0, 0,   5, 4, 104, 1, 0);

        // 2: stall 3 cycles at pc=5
        cyc(0, 1, 0, 0,   5, 4, 104, 1, 0);
        cyc(0, 1, 0, 0,   5, 4, 104, 1, 0);
        cyc(0, 1, 0, 0,   5, 4, 104, 1, 0);
        cyc(0, 0, 0, 0,   6, 5, 105, 1, 0);

        // 3: taken branch to 40 at pc=7
        cyc(0, 0, 0, 0,   7, 6, 106, 1, 0);
        cyc(0, 0, 1, 40,  40, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   41, 40, 140, 1, 0);

        // 4: branch to 20 under stall, stall held 2 more cycles
        cyc(0, 1, 1, 20,  41, 0, 0, 0, 1);
        cyc(0, 1, 0, 0,   41, 0, 0, 0, 1);
        cyc(0, 1, 0, 0,   41, 0, 0, 0, 1);
        cyc(0, 0, 0, 0,   20, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   21, 20, 120, 1, 0);

        // 5: pending 20 overwritten by 60 under stall
        cyc(0, 1, 1, 20,  21, 0, 0, 0, 1);
        cyc(0, 1, 1, 60,  21, 0, 0, 0, 1);
        cyc(0, 1, 0, 0,   21, 0, 0, 0, 1);
        cyc(0, 0, 0, 0,   60, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   61, 60, 160, 1, 0);

        // Unstalled branch overrides a pending redirect
        cyc(0, 1, 1, 30,  61, 0, 0, 0, 1);
        cyc(0, 0, 1, 90,  90, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   91, 90, 190, 1, 0);

        // 6: wrap at all-ones, then reset while pending
        cyc(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   0, 32'hFFFF_FFFF, 32'd99, 1, 0);
        cyc(0, 0, 0, 0,   1, 0, 100, 1, 0);
        cyc(0, 1, 1, 77,  1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0,   0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0,   1, 0, 100, 1, 0);
        cyc(0, 0, 0, 0,   2, 1, 101, 1, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
